// File: rtl/commit_dispatch_pkg.sv
// Types and constants shared by the commit dispatcher and its instruction FIFO.
package commit_dispatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RSP   = 2'd3
    } cd_state_e;

    localparam logic [1:0] RSP_OK  = 2'd0;
    localparam logic [1:0] RSP_ILL = 2'd1;
    localparam logic [1:0] RSP_TO  = 2'd2;

endpackage

// File: rtl/cd_fifo.sv
// Power-of-two instruction FIFO with synchronous flush and occupancy count.
module cd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full  = cnt_q[AW];
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // Simultaneous push/pop is accepted even at full or empty; on empty the
    // popped word is the one being pushed, so the occupancy stays put.
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & (~empty | push) & ~flush;
    assign dout    = empty ? din : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/commit_dispatch.sv
// Queues instructions, issues each to the unit named by its opcode field,
// waits for completion or timeout, and returns one response per instruction.
module commit_dispatch
    import commit_dispatch_pkg::*;
#(
    parameter int unsigned INS_W     = 32,
    parameter int unsigned NUM_UNITS = 8,
    parameter int unsigned OPC_LSB   = 28,
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TO_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_vaild,
    output logic                   req_ready,
    input  logic [INS_W-1:0]       r_in,
    output logic                   rsp_vaild,
    input  logic                   rsp_ready,
    output logic [OPC_W-1:0]       rsp_unit,
    output logic [1:0]             rsp_err,
    input  logic                   flush,
    input  logic [TO_W-1:0]        timeout_lim,
    output logic [NUM_UNITS-1:0]   unit_start,
    output logic [INS_W-1:0]       unit_ins,
    output logic [NUM_UNITS-1:0]   unit_abort,
    input  logic [NUM_UNITS-1:0]   unit_done,
    output logic [$clog2(DEPTH):0] q_count
);
    cd_state_e            state_q, state_d;
    logic [INS_W-1:0]     ins_q, ins_d;
    logic [1:0]           err_q, err_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic                 rdy_q;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [INS_W-1:0]     fifo_head;
    logic [OPC_W-1:0]     head_idx, idx;
    logic                 head_legal, done_hit, to_hit;
    logic [NUM_UNITS-1:0] sel;

    cd_fifo #(.WIDTH(INS_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (r_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // rdy_q keeps req_ready low through reset and the edge that releases it.
    assign req_ready  = rdy_q & ~fifo_full & ~flush;
    assign fifo_push  = req_vaild & req_ready;
    assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty & ~flush;

    assign head_idx   = fifo_head[OPC_LSB +: OPC_W];
    assign idx        = ins_q[OPC_LSB +: OPC_W];
    assign head_legal = (32'(head_idx) < NUM_UNITS);
    assign sel        = NUM_UNITS'(1) << idx;
    assign done_hit   = |(unit_done & sel);
    assign to_hit     = (timeout_lim != '0) && (cnt_q == timeout_lim - 1'b1);

    assign unit_ins   = ins_q;
    assign rsp_unit   = idx;
    assign rsp_err    = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ins_q   <= '0;
            err_q   <= RSP_OK;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    ins_d = fifo_head;
                    if (head_legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_RSP;
                        err_d   = RSP_ILL;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (done_hit) begin
                    state_d = S_RSP;
                    err_d   = RSP_OK;
                end else if (to_hit) begin
                    state_d = S_RSP;
                    err_d   = RSP_TO;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completion takes priority over a coincident timeout, so no abort then.
    always_comb begin
        unit_start = '0;
        unit_abort = '0;
        rsp_vaild  = 1'b0;
        case (state_q)
            S_ISSUE: unit_start = sel;
            S_WAIT:  if (!done_hit && to_hit) unit_abort = sel;
            S_RSP:   rsp_vaild = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_commit_dispatch.sv
// Scoreboard bench for commit_dispatch: stimulus queues expected starts and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_commit_dispatch;
    localparam int         NU  = 8;
    localparam logic [1:0] OK  = 2'd0;
    localparam logic [1:0] ILL = 2'd1;
    localparam logic [1:0] TO  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_vaild, req_ready;
    logic [31:0] r_in;
    logic        rsp_vaild, rsp_ready;
    logic [3:0]  rsp_unit;
    logic [1:0]  rsp_err;
    logic        flush;
    logic [15:0] timeout_lim;
    logic [7:0]  unit_start, unit_abort, unit_done;
    logic [31:0] unit_ins;
    logic [2:0]  q_count;

    commit_dispatch #(
        .INS_W(32), .NUM_UNITS(8), .OPC_LSB(28), .OPC_W(4), .DEPTH(4), .TO_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_vaild   (req_vaild),
        .req_ready   (req_ready),
        .r_in        (r_in),
        .rsp_vaild   (rsp_vaild),
        .rsp_ready   (rsp_ready),
        .rsp_unit    (rsp_unit),
        .rsp_err     (rsp_err),
        .flush       (flush),
        .timeout_lim (timeout_lim),
        .unit_start  (unit_start),
        .unit_ins    (unit_ins),
        .unit_abort  (unit_abort),
        .unit_done   (unit_done),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] unit; logic [1:0] err; } rsp_t;
    typedef struct packed { logic [7:0] mask; logic [31:0] ins; } start_t;

    rsp_t   exp_rsp[$];
    start_t exp_start[$];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int start_cyc = 0, abort_cyc = 0, push_cyc = 0;
    int n_starts = 0, n_aborts = 0, n0 = 0;
    logic [7:0] abort_mask = '0;
    int done_dly = 0;
    logic [7:0] bad_mask = '0;

    logic [31:0] bp_ins [6] = '{32'h0000_0010, 32'h1000_0011, 32'h4000_0012,
                                32'h6000_0013, 32'h7000_0014, 32'h2000_0015};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [1:0] err, input bit expect_it);
        int n = 0;
        logic [3:0] u;
        rsp_t r;
        start_t s;
        u = ins[31:28];
        if (expect_it) begin
            r.unit = u;
            r.err  = err;
            exp_rsp.push_back(r);
            if (int'(u) < NU) begin
                s.mask = 8'(1) << u;
                s.ins  = ins;
                exp_start.push_back(s);
            end
        end
        req_vaild = 1'b1;
        r_in      = ins;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push wait: req_ready stayed 0, required 1");
        end
        push_cyc = cyc;
        @(posedge clk);
        #1 req_vaild = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_rsp.size() != 0 || rsp_vaild) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL response wait: %0d responses outstanding, required 0", exp_rsp.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        rsp_t   er;
        start_t es;
        forever begin
            @(negedge clk);
            if (unit_start != '0) begin
                n_starts++;
                start_cyc = cyc;
                if (exp_start.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected start: got mask 0x%0h, required none", unit_start);
                end else begin
                    es = exp_start.pop_front();
                    check("start mask", 32'(unit_start), 32'(es.mask));
                    check("start ins", unit_ins, es.ins);
                end
            end
            if (unit_abort != '0) begin
                n_aborts++;
                abort_cyc  = cyc;
                abort_mask = unit_abort;
            end
            if (rsp_vaild && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected rsp: got unit %0d err %0d, required none", rsp_unit, rsp_err);
                end else begin
                    er = exp_rsp.pop_front();
                    check("rsp unit", 32'(rsp_unit), 32'(er.unit));
                    check("rsp err", 32'(rsp_err), 32'(er.err));
                end
            end
        end
    end

    // Functional-unit model: completes after done_dly cycles, or signals a wrong unit
    initial begin
        logic [7:0] m;
        unit_done = '0;
        forever begin
            @(negedge clk);
            if (unit_start != '0 && (done_dly != 0 || bad_mask != '0)) begin
                m = (done_dly != 0) ? unit_start : bad_mask;
                repeat ((done_dly != 0) ? done_dly : 3) @(posedge clk);
                #1 unit_done = m;
                @(posedge clk);
                #1 unit_done = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_vaild = 1'b0; r_in = '0; rsp_ready = 1'b1;
        flush = 1'b0; timeout_lim = '0;
        #3;
        check("reset q_count", 32'(q_count), 0);
        check("reset req_ready", 32'(req_ready), 0);
        check("reset rsp_vaild", 32'(rsp_vaild), 0);
        check("reset unit_start", 32'(unit_start), 0);
        check("reset unit_abort", 32'(unit_abort), 0);
        check("reset rsp_unit", 32'(rsp_unit), 0);
        check("reset rsp_err", 32'(rsp_err), 0);
        check("reset unit_ins", unit_ins, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready after release", 32'(req_ready), 1);

        // Legal dispatch to unit 2
        done_dly = 5;
        push(32'h2000_0001, OK, 1'b1);
        wait_idle();
        check("start latency", 32'(start_cyc - push_cyc), 2);

        // Illegal unit 9
        done_dly = 0;
        n0 = n_starts;
        push(32'h9000_0000, ILL, 1'b1);
        wait_idle();
        check("illegal no start", 32'(n_starts - n0), 0);

        // Timeout on unit 3, with a stray done from unit 4
        timeout_lim = 16'd10;
        bad_mask = 8'h10;
        n0 = n_aborts;
        push(32'h3000_00AB, TO, 1'b1);
        wait_idle();
        bad_mask = '0;
        check("timeout abort count", 32'(n_aborts - n0), 1);
        check("timeout abort mask", 32'(abort_mask), 32'h08);
        check("timeout abort delay", 32'(abort_cyc - start_cyc), 10);

        // Done on the timeout cycle wins
        done_dly = 10;
        n0 = n_aborts;
        push(32'h5000_0005, OK, 1'b1);
        wait_idle();
        check("race no abort", 32'(n_aborts - n0), 0);
        timeout_lim = '0;

        // Backpressure: one issued, four queued, sixth waits
        done_dly = 2;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(bp_ins[i], OK, 1'b1);
        fork
            push(bp_ins[5], OK, 1'b1);
            begin
                @(negedge clk);
                check("full q_count", 32'(q_count), 4);
                check("full req_ready", 32'(req_ready), 0);
                repeat (2) @(negedge clk);
                check("stalled rsp_vaild", 32'(rsp_vaild), 1);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Flush with three queued; in-flight instruction still responds
        rsp_ready = 1'b0;
        push(32'h1000_0021, OK, 1'b1);
        push(32'h2000_0022, OK, 1'b0);
        push(32'h3000_0023, OK, 1'b0);
        push(32'h4000_0024, OK, 1'b0);
        @(negedge clk);
        check("pre-flush q_count", 32'(q_count), 3);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("post-flush q_count", 32'(q_count), 0);
        n0 = n_starts;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check("flushed no start", 32'(n_starts - n0), 0);

        // Flush on the pop cycle wins
        n0 = n_starts;
        push(32'h3000_0031, OK, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush-pop q_count", 32'(q_count), 0);
        repeat (4) @(posedge clk);
        #1;
        check("flush-pop no start", 32'(n_starts - n0), 0);
        check("flush-pop no rsp", 32'(rsp_vaild), 0);

        // Reset during WAIT
        done_dly = 0;
        n0 = n_aborts;
        push(32'h6000_0041, OK, 1'b1);
        push(32'h1000_0042, OK, 1'b0);
        push(32'h2000_0043, OK, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        check("mid reset rsp_vaild", 32'(rsp_vaild), 0);
        check("mid reset unit_abort", 32'(unit_abort), 0);
        check("mid reset q_count", 32'(q_count), 0);
        check("mid reset req_ready", 32'(req_ready), 0);
        check("mid reset unit_ins", unit_ins, 0);
        exp_rsp.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        done_dly = 3;
        push(32'h0000_0051, OK, 1'b1);
        wait_idle();
        check("reset no abort", 32'(n_aborts - n0), 0);

        check("leftover starts", 32'(exp_start.size()), 0);
        check("leftover rsps", 32'(exp_rsp.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_dispatch.md
COMMIT_DISPATCH -- requirements
Module: commit_dispatch

Interface
REQ-001 Parameter INS_W, default 32, instruction width in bits.
REQ-002 Parameter NUM_UNITS, default 8, number of functional units, range 1..16.
REQ-003 Parameter OPC_LSB, default 28, LSB of the unit-select field in the instruction.
REQ-004 Parameter OPC_W, default 4, width of the unit-select field.
REQ-005 Parameter DEPTH, default 4, instruction FIFO depth; must be a power of 2 and at least 2.
REQ-006 Parameter TO_W, default 16, width of the timeout counter.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 Clock and reset ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
REQ-009 Request, response and control ports:
- req_vaild  in  1  instruction offered.
- req_ready  out  1  instruction accepted when high together with req_vaild.
- r_in  in  INS_W  instruction word.
- rsp_vaild  out  1  completion response valid.
- rsp_ready  in  1  response consumed.
- rsp_unit  out  OPC_W  unit index of the completed instruction.
- rsp_err  out  2  completion code: 0 ok, 1 illegal unit, 2 timeout.
- flush  in  1  synchronous; discards queued (not yet issued) instructions.
- timeout_lim  in  TO_W  WAIT-cycle limit; 0 disables the timeout.
- unit_start  out  NUM_UNITS  one-hot start pulse.
- unit_ins  out  INS_W  instruction bus to the units.
- unit_abort  out  NUM_UNITS  one-hot abort pulse.
- unit_done  in  NUM_UNITS  per-unit completion.
- q_count  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-010 req_ready = ~full & ~flush; an instruction is pushed on a cycle with req_vaild & req_ready.
REQ-011 FSM states: IDLE, ISSUE, WAIT, RSP.
REQ-012 IDLE, FIFO non-empty: pop the head into ins_q; decode idx = ins_q[OPC_LSB +: OPC_W]. idx < NUM_UNITS -> ISSUE; otherwise -> RSP with rsp_err=1.
REQ-013 ISSUE: unit_start[idx]=1 for exactly one cycle; clear the timeout counter; -> WAIT.
REQ-014 unit_ins = ins_q, held stable from ISSUE until the state leaves RSP.
REQ-015 WAIT: counter increments each cycle.
- unit_done[idx]=1 -> RSP, rsp_err=0.
- Else if timeout_lim!=0 and the counter reaches timeout_lim-1 -> unit_abort[idx] one-cycle pulse, -> RSP, rsp_err=2.
REQ-016 If unit_done and the timeout condition occur in the same cycle, done wins: no abort, rsp_err=0.
REQ-017 unit_done is ignored during ISSUE, and from any unit other than idx.
REQ-018 RSP: rsp_vaild=1, with rsp_unit and rsp_err stable until rsp_ready; on the rsp_ready cycle -> IDLE, and rsp_vaild=0 on the next cycle.
REQ-019 Latency: a push into an empty FIFO with FSM in IDLE at cycle 0 gives the pop at cycle 1 and unit_start at cycle 2.
REQ-020 Push and pop in the same cycle when the FIFO is full or empty is legal; the occupancy is unchanged.
REQ-021 Pointers wrap modulo DEPTH.
REQ-022 flush empties the FIFO next cycle and overrides a same-cycle pop (nothing popped, FSM stays IDLE); it does not affect an issued instruction in ISSUE, WAIT or RSP.
REQ-023 The counter saturates at all-ones and does not wrap.

Reset
REQ-024 On reset low, immediately:
- FSM = IDLE; FIFO empty; q_count = 0.
- req_ready = 0 while reset is asserted, and 1 from the first clk after release.
- rsp_vaild, unit_start, unit_abort = 0; rsp_unit, rsp_err, unit_ins = 0.
REQ-025 Reset mid-operation discards the in-flight instruction without an abort pulse.

Structure
REQ-026 A shared package holds:
- the FSM state encoding;
- rsp_err codes RSP_OK=0, RSP_ILL=1, RSP_TO=2.
REQ-027 The FIFO is one sub-module, cd_fifo, parametrised by width and depth, with push, pop, flush, full, empty and count.

Verification
REQ-028 Legal dispatch: push 0x2000_0001 (unit 2); unit_done[2] asserted 5 cycles after start.
- unit_start=0x04 at cycle 2; unit_ins=0x2000_0001.
- rsp_vaild with rsp_unit=2, rsp_err=0.
REQ-029 Illegal unit: NUM_UNITS=8, push 0x9000_0000.
- No unit_start.
- rsp_err=1, rsp_unit=9.
REQ-030 Timeout: timeout_lim=10, unit 3 never completes.
- unit_abort=0x08 exactly 10 cycles after unit_start.
- rsp_err=2.
REQ-031 Backpressure and full: hold rsp_ready=0 and push 6 instructions.
- req_ready drops after 1 issued + 4 queued; q_count=4.
- Release rsp_ready: responses return in order.
REQ-032 Race and flush:
- unit_done on the timeout cycle -> rsp_err=0, no abort.
- flush with 3 queued -> q_count=0 next cycle; the in-flight instruction still responds.
REQ-033 Reset during WAIT: rsp_vaild=0, unit_abort=0, q_count=0 immediately; a new instruction dispatches normally afterwards.
